// File: rtl/md_cart_responder.sv
// Cartridge-port word-read responder with a one-word sequential prefetch buffer over a req/ack backing memory.
// Hit serves 2 MCLK after the pins; miss serves in the mem_ack cycle; memory stalls by withholding mem_ack.
module md_cart_responder #(
    parameter int ADDR_W   = 21,
    parameter int DATA_W   = 16,
    parameter bit PREFETCH = 1'b1
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] cart_address,
    input  logic              cart_cs,
    input  logic              cart_oe,
    output logic [DATA_W-1:0] cart_data,
    output logic              cart_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       hit_count
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FETCH    = 2'd1;
    localparam logic [1:0] S_PREFETCH = 2'd2;
    localparam logic [1:0] S_PF_WAIT  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] a_r, a_q, pend_addr, srv_addr, pf_addr, acc_addr;
    logic              cs_r, oe_r, act_q, pend_vld, pf_valid;
    logic [DATA_W-1:0] pf_data;
    logic              act_r, new_acc, acc_go, acc_hit, ack;

    assign act_r    = cs_r & oe_r;
    assign new_acc  = act_r & (~act_q | (a_r != a_q));
    // A fresh access takes priority over one parked while memory was busy.
    assign acc_go   = act_r & (new_acc | pend_vld);
    assign acc_addr = new_acc ? a_r : pend_addr;
    assign acc_hit  = pf_valid & (pf_addr == acc_addr);
    assign ack      = mem_req & mem_ack;

    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_IDLE;
            a_r        <= '0;
            a_q        <= '0;
            cs_r       <= 1'b0;
            oe_r       <= 1'b0;
            act_q      <= 1'b0;
            pend_vld   <= 1'b0;
            pend_addr  <= '0;
            srv_addr   <= '0;
            pf_valid   <= 1'b0;
            pf_addr    <= '0;
            pf_data    <= '0;
            cart_data  <= '1;
            cart_ready <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            hit_count  <= '0;
        end else begin
            a_r   <= cart_address;
            cs_r  <= cart_cs;
            oe_r  <= cart_oe;
            a_q   <= a_r;
            act_q <= act_r;

            if (!act_r || new_acc)
                cart_ready <= 1'b0;

            // An abandoned access is forgotten; a newer one overwrites the parked one.
            if (!act_r)
                pend_vld <= 1'b0;
            else if (new_acc) begin
                pend_vld  <= 1'b1;
                pend_addr <= a_r;
            end

            case (state)
                S_IDLE: begin
                    if (acc_go) begin
                        pend_vld <= 1'b0;
                        if (acc_hit) begin
                            cart_data  <= pf_data;
                            cart_ready <= 1'b1;
                            srv_addr   <= acc_addr;
                            if (hit_count != 16'hFFFF)
                                hit_count <= hit_count + 16'd1;
                            state <= PREFETCH ? S_PREFETCH : S_IDLE;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= acc_addr;
                            pf_valid <= 1'b0;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (ack) begin
                        mem_req <= 1'b0;
                        // Serve only if the access that launched this fetch is still the live one.
                        if (act_r && !new_acc && !pend_vld) begin
                            cart_data  <= mem_rdata;
                            cart_ready <= 1'b1;
                            srv_addr   <= mem_addr;
                            state      <= PREFETCH ? S_PREFETCH : S_IDLE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_PREFETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= srv_addr + 1'b1;
                        if (new_acc)
                            state <= S_PF_WAIT;
                    end else if (ack) begin
                        mem_req  <= 1'b0;
                        pf_data  <= mem_rdata;
                        pf_addr  <= mem_addr;
                        pf_valid <= 1'b1;
                        state    <= S_IDLE;
                    end else if (new_acc) begin
                        state <= S_PF_WAIT;
                    end
                end
                default: begin
                    if (ack) begin
                        mem_req  <= 1'b0;
                        pf_data  <= mem_rdata;
                        pf_addr  <= mem_addr;
                        pf_valid <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/md_cart_responder.md
# md_cart_responder

Cartridge-side responder for the console cartridge port. It answers word reads that the board issues on `cart_address`/`cart_cs`/`cart_oe` and returns `cart_data` from a slower backing memory (SDRAM/SRAM controller) through a req/ack handshake. A one-word sequential prefetch buffer hides backing-memory latency for linear 68k fetches. It runs on MCLK alongside the board top.

## Interface
Parameters:
- `ADDR_W`, 21: cartridge word-address width.
- `DATA_W`, 16: data width.
- `PREFETCH`, 1: 1 = fetch addr+1 after every served access; 0 = no prefetch, and every access goes to backing memory.

Ports:
- `MCLK`  in  1  system clock; every register is on its rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `cart_address`  in  ADDR_W  word address from the console.
- `cart_cs`  in  1  chip select, active-high.
- `cart_oe`  in  1  output enable, active-high.
- `cart_data`  out  DATA_W  read data to the console.
- `cart_ready`  out  1  high while `cart_data` holds the word for the current access.
- `mem_req`  out  1  backing-memory read request.
- `mem_addr`  out  ADDR_W  backing-memory word address.
- `mem_ack`  in  1  one-cycle acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  DATA_W  backing-memory read data.
- `hit_count`  out  16  saturating count of accesses served from the prefetch buffer.

## Operation
- Input stage: `cart_address`, `cart_cs` and `cart_oe` are registered every MCLK as `a_r`, `cs_r`, `oe_r`. `act_r = cs_r & oe_r`.
- New access: `act_r` rises, or `act_r` stays high while `a_r` differs from the previous cycle's `a_r`. The access address is `a_r`.
- When `act_r` falls, `cart_ready` drops on the next edge. `cart_data` keeps its last value.
- Prefetch buffer: `pf_addr`, `pf_data` and `pf_valid`. A hit is `pf_valid & (pf_addr == access address)`.
- States:
  - IDLE: no memory transaction in flight.
    - New access that hits: load `cart_data` from `pf_data`, set `cart_ready`, increment `hit_count`, go to PREFETCH. With `PREFETCH`=0, stay in IDLE.
    - New access that misses: assert `mem_req` with `mem_addr` = access address, clear `pf_valid`, go to FETCH.
  - FETCH: on `mem_ack`, load `cart_data` from `mem_rdata`, set `cart_ready`, drop `mem_req`. Then go to PREFETCH, or to IDLE when `PREFETCH`=0.
  - PREFETCH:
    - Entry cycle: assert `mem_req` with `mem_addr` = served address + 1. Arithmetic is modulo 2^ADDR_W, so 21'h1FFFFF wraps to 0.
    - On `mem_ack`: write `pf_data`, set `pf_addr` and `pf_valid`, go to IDLE.
  - PF_WAIT: entered from PREFETCH when a new access arrives before `mem_ack`. The pending access address is latched.
    - On `mem_ack`: fill the buffer as in PREFETCH, then re-evaluate the pending access as if in IDLE (hit or miss) on the next cycle.
- Request rules:
  - `mem_req` and `mem_addr` stay stable from assertion until the ack cycle.
  - A request is never withdrawn, including when the console abandons the access.
  - `mem_req` drops in the cycle after `mem_ack`.
  - `mem_ack` while `mem_req` is low is ignored.
- Simultaneous `mem_ack` and new access in PREFETCH: complete the fill first. The access is then evaluated next cycle against the updated buffer.
- A second new access while in FETCH or PF_WAIT replaces the pending one; only the latest access is served.
- `hit_count` saturates at 16'hFFFF.

## Timing
- Reset values:
  - `cart_data` = 16'hFFFF (open bus).
  - `cart_ready` = 0, `mem_req` = 0, `mem_addr` = 0, `hit_count` = 0.
  - `pf_valid` = 0; state IDLE.
- Reset asserted mid-transaction returns everything to these values immediately. A later `mem_ack` from the aborted request is ignored.
- Hit latency: inputs high before edge E0 → `act_r` at E0 → `cart_data`/`cart_ready` valid after E1. Total 2 MCLK.
- Miss latency: `mem_req` rises after E1. `mem_ack` sampled at edge Ek → `cart_data`/`cart_ready` valid after Ek. The prefetch `mem_req` rises after Ek+1.
- The earliest possible `mem_ack` is the edge after `mem_req` rises; the block must accept that.

## Test plan
- Cold miss:
  - Stimulus: read address 0x000100; memory acks 5 cycles after `mem_req` with 0xA5A5.
  - Required: `cart_data` = 0xA5A5 with `cart_ready` = 1; then `mem_req` for 0x000101; `hit_count` = 0.
- Sequential hit:
  - Stimulus: after the cold miss and its prefetch fill (0x1234), read 0x000101.
  - Required: `cart_data` = 0x1234 two MCLK after the inputs rise, no `mem_req` issued for 0x000101, `hit_count` = 1, prefetch of 0x000102 issued.
- Non-sequential during prefetch:
  - Stimulus: read 0x000200 while the prefetch of 0x000102 is outstanding.
  - Required: the 0x000102 fill completes; a new `mem_req` goes out for 0x000200; the access is served with its data; `hit_count` is unchanged.
- Wrap-around:
  - Stimulus: read 0x1FFFFF.
  - Required: the prefetch `mem_addr` is 0x000000; a following read of 0x000000 is a hit.
- Reset mid-fetch:
  - Stimulus: drop `RESET` while `mem_req` is high; ack arrives after release.
  - Required: outputs show reset values (`cart_data` = 0xFFFF, `mem_req` = 0) immediately; the stray ack is ignored; the next read is a miss.
- `PREFETCH`=0:
  - Stimulus: two sequential reads.
  - Required: two `mem_req` transactions, no prefetch request, `hit_count` = 0.
